// File: rtl/conv_tile_sequencer.sv
// rtl/conv_tile_sequencer.sv - raster-order conv window sequencer with result write-back
module conv_tile_sequencer #(
  parameter int DIM_W  = 8,
  parameter int DATA_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [DIM_W-1:0]        in_h,
  input  logic [DIM_W-1:0]        in_w,
  input  logic [3:0]              kernel_size,
  input  logic [3:0]              stride,
  input  logic [3:0]              padding,
  output logic                    win_valid,
  input  logic                    win_ready,
  output logic signed [DIM_W:0]   win_row,
  output logic signed [DIM_W:0]   win_col,
  input  logic                    res_valid,
  input  logic [DATA_W-1:0]       res_data,
  output logic                    res_ready,
  output logic                    wr_en,
  output logic [2*DIM_W-1:0]      wr_addr,
  output logic [DATA_W-1:0]       wr_data,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int CW = DIM_W + 4;

  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, WRITE, FIN} state_t;

  state_t                  state;
  logic [DIM_W-1:0]        h_q, w_q;
  logic [3:0]              k_q, s_q, p_q;
  logic signed [DIM_W:0]   row, col;
  logic [2*DIM_W-1:0]      idx;

  logic signed [CW-1:0]    h_x, w_x, k_x, s_x, p_x, row_x, col_x, row_adv_x;
  logic signed [DIM_W:0]   s_n, neg_p, col_adv, row_adv;
  logic                    wrap, last, geom_err;

  // Bounds are evaluated in a widened signed domain so maximal dimensions plus padding cannot wrap.
  always_comb begin
    h_x       = $signed({4'b0000, h_q});
    w_x       = $signed({4'b0000, w_q});
    k_x       = $signed({{DIM_W{1'b0}}, k_q});
    s_x       = $signed({{DIM_W{1'b0}}, s_q});
    p_x       = $signed({{DIM_W{1'b0}}, p_q});
    row_x     = $signed({{3{row[DIM_W]}}, row});
    col_x     = $signed({{3{col[DIM_W]}}, col});
    s_n       = $signed({{(DIM_W-3){1'b0}}, s_q});
    neg_p     = -$signed({{(DIM_W-3){1'b0}}, p_q});
    wrap      = (col_x + s_x + k_x) > (w_x + p_x);
    col_adv   = wrap ? neg_p : col + s_n;
    row_adv   = wrap ? row + s_n : row;
    row_adv_x = wrap ? row_x + s_x : row_x;
    last      = (row_adv_x + k_x) > (h_x + p_x);
    geom_err  = (k_q == 4'd0) || (s_q == 4'd0) ||
                (k_x > h_x + p_x + p_x) || (k_x > w_x + p_x + p_x);
  end

  assign busy    = (state != IDLE);
  assign win_row = row;
  assign win_col = col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      h_q       <= '0;
      w_q       <= '0;
      k_q       <= '0;
      s_q       <= '0;
      p_q       <= '0;
      row       <= '0;
      col       <= '0;
      idx       <= '0;
      win_valid <= 1'b0;
      res_ready <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done  <= 1'b0;
      err   <= 1'b0;
      wr_en <= 1'b0;
      if (state != IDLE && abort) begin
        state     <= IDLE;
        win_valid <= 1'b0;
        res_ready <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            h_q   <= in_h;
            w_q   <= in_w;
            k_q   <= kernel_size;
            s_q   <= stride;
            p_q   <= padding;
            idx   <= '0;
            state <= CHECK;
          end
          CHECK: if (geom_err) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            row       <= neg_p;
            col       <= neg_p;
            win_valid <= 1'b1;
            state     <= ISSUE;
          end
          ISSUE: if (win_ready) begin
            win_valid <= 1'b0;
            res_ready <= 1'b1;
            state     <= WAIT;
          end
          WAIT: if (res_valid) begin
            res_ready <= 1'b0;
            wr_data   <= res_data;
            wr_addr   <= idx;
            wr_en     <= 1'b1;
            idx       <= idx + {{(2*DIM_W-1){1'b0}}, 1'b1};
            state     <= WRITE;
          end
          WRITE: begin
            row <= row_adv;
            col <= col_adv;
            if (last) begin
              state <= FIN;
            end else begin
              win_valid <= 1'b1;
              state     <= ISSUE;
            end
          end
          FIN: begin
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv_tile_sequencer.sv
// tb/tb_conv_tile_sequencer.sv - directed self-checking bench for conv_tile_sequencer
module tb_conv_tile_sequencer;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start, abort;
  logic [7:0]        in_h, in_w;
  logic [3:0]        kernel_size, stride, padding;
  logic              win_valid, win_ready;
  logic signed [8:0] win_row, win_col;
  logic              res_valid, res_ready;
  logic [15:0]       res_data;
  logic              wr_en;
  logic [15:0]       wr_addr, wr_data;
  logic              busy, done, err;

  int checks = 0;
  int errors = 0;

  int nwin, nvalid, nwr, ndone, nerr, first_win, done_cyc, overlap;
  logic done_busy;
  logic signed [8:0] win_r[$];
  logic signed [8:0] win_c[$];
  logic [15:0] wr_a[$];
  logic [15:0] wr_d[$];

  always #5 clk = ~clk;

  conv_tile_sequencer #(.DIM_W(8), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_h(in_h), .in_w(in_w), .kernel_size(kernel_size), .stride(stride), .padding(padding),
    .win_valid(win_valid), .win_ready(win_ready), .win_row(win_row), .win_col(win_col),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Geometry inputs are scrambled right after launch to prove they were captured.
  task automatic pulse_start(input int h, input int w, input int k, input int s, input int p, input logic ab);
    in_h = 8'(h); in_w = 8'(w); kernel_size = 4'(k); stride = 4'(s); padding = 4'(p);
    start = 1'b1; abort = ab;
    tick;
    start = 1'b0; abort = 1'b0;
    in_h = 8'd1; in_w = 8'd1; kernel_size = 4'd15; stride = 4'd0; padding = 4'd0;
  endtask

  task automatic run_job(input int budget);
    nwin = 0; nvalid = 0; nwr = 0; ndone = 0; nerr = 0;
    first_win = -1; done_cyc = -1; overlap = 0; done_busy = 1'b1;
    win_r.delete(); win_c.delete(); wr_a.delete(); wr_d.delete();
    res_data = 16'h1000;
    for (int c = 1; c <= budget; c++) begin
      tick;
      if (win_valid && wr_en) overlap++;
      if (win_valid) nvalid++;
      if (win_valid && win_ready) begin
        if (nwin == 0) first_win = c;
        win_r.push_back(win_row);
        win_c.push_back(win_col);
        nwin++;
      end
      if (wr_en) begin
        wr_a.push_back(wr_addr);
        wr_d.push_back(wr_data);
        nwr++;
        res_data = 16'h1000 + 16'(nwr);
      end
      if (done) begin
        ndone++;
        done_cyc = c;
        done_busy = busy;
        if (err) nerr++;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick; tick;
    checks++;
    if ({win_valid, win_row, win_col, res_ready, wr_en, wr_addr, wr_data, busy, done, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got win_valid=%b row=%0d col=%0d res_ready=%b wr_en=%b addr=%0d data=%h busy=%b done=%b err=%b, all must be 0",
               win_valid, win_row, win_col, res_ready, wr_en, wr_addr, wr_data, busy, done, err);
    end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_basic_4x4;
    win_ready = 1'b1; res_valid = 1'b1;
    pulse_start(4, 4, 3, 1, 0, 1'b0);
    checks++;
    if (busy !== 1'b1 || win_valid !== 1'b0) begin
      errors++; $display("FAIL basic_check_state: busy=%b win_valid=%b, required 1/0", busy, win_valid);
    end
    run_job(100);
    checks++;
    if (nwin !== 4 || nwr !== 4) begin
      errors++; $display("FAIL basic_count: windows=%0d writes=%0d, required 4/4", nwin, nwr);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (int'(win_r[i]) !== i / 2 || int'(win_c[i]) !== i % 2 || wr_a[i] !== 16'(i) || wr_d[i] !== 16'h1000 + 16'(i)) begin
        errors++;
        $display("FAIL basic_win%0d: origin (%0d,%0d) addr %0d data %h, required (%0d,%0d) addr %0d data %h",
                 i, win_r[i], win_c[i], wr_a[i], wr_d[i], i / 2, i % 2, i, 16'h1000 + 16'(i));
      end
    end
    checks++;
    if (first_win !== 1 || done_cyc !== 14 || nerr !== 0 || done_busy !== 1'b0 || overlap !== 0) begin
      errors++;
      $display("FAIL basic_timing: first_win=%0d done_cyc=%0d err=%0d busy_at_done=%b overlap=%0d, required 1/14/0/0/0",
               first_win, done_cyc, nerr, done_busy, overlap);
    end
  endtask

  task automatic test_padding_5x5;
    win_ready = 1'b1; res_valid = 1'b1;
    pulse_start(5, 5, 3, 2, 1, 1'b0);
    run_job(100);
    checks++;
    if (nwin !== 9 || ndone !== 1 || nerr !== 0) begin
      errors++; $display("FAIL pad_count: windows=%0d done=%0d err=%0d, required 9/1/0", nwin, ndone, nerr);
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (int'(win_r[i]) !== -1 + 2 * (i / 3) || int'(win_c[i]) !== -1 + 2 * (i % 3)) begin
        errors++;
        $display("FAIL pad_win%0d: origin (%0d,%0d), required (%0d,%0d)", i, win_r[i], win_c[i], -1 + 2 * (i / 3), -1 + 2 * (i % 3));
      end
    end
    checks++;
    if (wr_a[8] !== 16'd8) begin
      errors++; $display("FAIL pad_last_addr: got %0d, required 8", wr_a[8]);
    end
  endtask

  task automatic test_geom_err;
    win_ready = 1'b1; res_valid = 1'b1;
    pulse_start(4, 4, 3, 0, 0, 1'b0);
    run_job(20);
    checks++;
    if (done_cyc !== 1 || nerr !== 1 || nvalid !== 0 || done_busy !== 1'b0) begin
      errors++; $display("FAIL err_stride0: done_cyc=%0d err=%0d win_valid_cycles=%0d busy=%b, required 1/1/0/0", done_cyc, nerr, nvalid, done_busy);
    end
    pulse_start(2, 2, 7, 1, 0, 1'b0);
    run_job(20);
    checks++;
    if (done_cyc !== 1 || nerr !== 1 || nvalid !== 0) begin
      errors++; $display("FAIL err_kernel7: done_cyc=%0d err=%0d win_valid_cycles=%0d, required 1/1/0", done_cyc, nerr, nvalid);
    end
    // K exactly equal to in+2P is legal and yields a single padded window.
    pulse_start(2, 2, 4, 1, 1, 1'b0);
    run_job(30);
    checks++;
    if (nwin !== 1 || nerr !== 0 || ndone !== 1 || int'(win_r[0]) !== -1 || int'(win_c[0]) !== -1) begin
      errors++; $display("FAIL exact_fit: windows=%0d err=%0d done=%0d origin (%0d,%0d), required 1/0/1 (-1,-1)", nwin, nerr, ndone, win_r[0], win_c[0]);
    end
  endtask

  task automatic test_max_dim;
    win_ready = 1'b1; res_valid = 1'b1;
    pulse_start(255, 255, 15, 15, 0, 1'b0);
    run_job(2000);
    checks++;
    if (nwin !== 289 || nerr !== 0 || ndone !== 1) begin
      errors++; $display("FAIL max_dim_count: windows=%0d err=%0d done=%0d, required 289/0/1", nwin, nerr, ndone);
    end
    checks++;
    if (int'(win_r[288]) !== 240 || int'(win_c[288]) !== 240 || wr_a[288] !== 16'd288) begin
      errors++; $display("FAIL max_dim_last: origin (%0d,%0d) addr %0d, required (240,240) addr 288", win_r[288], win_c[288], wr_a[288]);
    end
  endtask

  task automatic test_stall;
    int nwe;
    nwe = 0;
    win_ready = 1'b0; res_valid = 1'b0; res_data = 16'h0000;
    pulse_start(3, 3, 3, 2, 1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick;
      if (wr_en) nwe++;
      checks++;
      if (win_valid !== 1'b1 || win_row !== 9'h1FF || win_col !== 9'h1FF) begin
        errors++; $display("FAIL stall_issue%0d: win_valid=%b origin (%0d,%0d), required 1 (-1,-1)", i, win_valid, win_row, win_col);
      end
    end
    win_ready = 1'b1;
    tick;
    win_ready = 1'b0;
    checks++;
    if (win_valid !== 1'b0 || res_ready !== 1'b1) begin
      errors++; $display("FAIL stall_wait_entry: win_valid=%b res_ready=%b, required 0/1", win_valid, res_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      if (wr_en) nwe++;
    end
    checks++;
    if (res_ready !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL stall_wait_hold: res_ready=%b busy=%b, required 1/1", res_ready, busy);
    end
    res_valid = 1'b1; res_data = 16'hBEEF;
    tick;
    res_valid = 1'b0;
    if (wr_en) nwe++;
    checks++;
    if (wr_en !== 1'b1 || wr_data !== 16'hBEEF || wr_addr !== 16'd0 || res_ready !== 1'b0) begin
      errors++; $display("FAIL stall_write: wr_en=%b data=%h addr=%0d res_ready=%b, required 1/beef/0/0", wr_en, wr_data, wr_addr, res_ready);
    end
    tick;
    if (wr_en) nwe++;
    checks++;
    if (nwe !== 1 || win_valid !== 1'b1 || win_row !== 9'h1FF || win_col !== 9'sd1) begin
      errors++; $display("FAIL stall_next: writes=%0d win_valid=%b origin (%0d,%0d), required 1/1 (-1,1)", nwe, win_valid, win_row, win_col);
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || win_valid !== 1'b0) begin
      errors++; $display("FAIL abort_issue: busy=%b win_valid=%b, required 0/0", busy, win_valid);
    end
  endtask

  task automatic test_abort;
    int late;
    late = 0;
    win_ready = 1'b1; res_valid = 1'b1; res_data = 16'h1234;
    pulse_start(4, 4, 3, 1, 0, 1'b0);
    tick; tick; tick;
    res_valid = 1'b0;
    tick; tick;
    checks++;
    if (res_ready !== 1'b1 || win_valid !== 1'b0) begin
      errors++; $display("FAIL abort_setup: res_ready=%b win_valid=%b, required 1/0", res_ready, win_valid);
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || res_ready !== 1'b0 || wr_en !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL abort_wait: busy=%b res_ready=%b wr_en=%b done=%b err=%b, required all 0", busy, res_ready, wr_en, done, err);
    end
    res_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (wr_en || done || res_ready || win_valid || busy) late++;
    end
    res_valid = 1'b0;
    checks++;
    if (late !== 0) begin
      errors++; $display("FAIL abort_late_result: %0d active cycles after abort, required 0", late);
    end
  endtask

  task automatic test_back_to_back;
    win_ready = 1'b1; res_valid = 1'b1;
    pulse_start(3, 3, 3, 1, 0, 1'b1);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL start_beats_abort: busy=%b, required 1", busy);
    end
    tick;
    pulse_start(5, 5, 3, 1, 0, 1'b0);
    run_job(50);
    tick;
    checks++;
    if (nwr !== 1 || ndone !== 1 || nerr !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL start_while_busy: writes=%0d done=%0d err=%0d busy_after=%b, required 1/1/0/0", nwr, ndone, nerr, busy);
    end
  endtask

  task automatic test_reset_midjob;
    win_ready = 1'b1; res_valid = 1'b1;
    pulse_start(4, 4, 3, 1, 0, 1'b0);
    for (int i = 0; i < 7; i++) tick;
    rst_n = 1'b0;
    #2;
    checks++;
    if ({win_valid, res_ready, wr_en, wr_addr, wr_data, busy, done, err, win_row, win_col} !== '0) begin
      errors++; $display("FAIL reset_async: win_valid=%b res_ready=%b wr_en=%b addr=%0d data=%h busy=%b, required all 0",
                         win_valid, res_ready, wr_en, wr_addr, wr_data, busy);
    end
    tick; tick;
    rst_n = 1'b1;
    tick;
    pulse_start(3, 3, 3, 1, 0, 1'b0);
    run_job(50);
    checks++;
    if (nwin !== 1 || int'(win_r[0]) !== 0 || int'(win_c[0]) !== 0 || wr_a[0] !== 16'd0 || ndone !== 1 || nerr !== 0) begin
      errors++; $display("FAIL reset_newjob: windows=%0d origin (%0d,%0d) addr %0d done=%0d err=%0d, required 1 (0,0) 0 1 0",
                         nwin, win_r[0], win_c[0], wr_a[0], ndone, nerr);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    in_h = '0; in_w = '0; kernel_size = '0; stride = '0; padding = '0;
    win_ready = 1'b0; res_valid = 1'b0; res_data = '0;
    test_reset;
    test_basic_4x4;
    test_padding_5x5;
    test_geom_err;
    test_max_dim;
    test_stall;
    test_abort;
    test_back_to_back;
    test_reset_midjob;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_tile_sequencer.md
CONV_TILE_SEQUENCER -- requirements
Module: conv_tile_sequencer

Interface
REQ-001 SHALL have parameter DIM_W, default 8, which sets the feature-map dimension width.
REQ-002 SHALL have parameter DATA_W, default 16, which sets the result data width.
REQ-003 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1 bit: one-cycle job launch pulse.
REQ-006 SHALL have port abort, input, 1 bit: cancel the current job.
REQ-007 SHALL have ports in_h and in_w, input, DIM_W bits each: input feature-map height and width.
REQ-008 SHALL have ports kernel_size, stride and padding, input, 4 bits each: conv geometry.
REQ-009 SHALL have port win_valid, output, 1 bit: window request to the conv engine.
REQ-010 SHALL have port win_ready, input, 1 bit: the conv engine accepts the window.
REQ-011 SHALL have ports win_row and win_col, output, DIM_W+1 bits each, signed: window origin (top-left), which may be negative under padding.
REQ-012 SHALL have port res_valid, input, 1 bit; port res_data, input, DATA_W bits; and port res_ready, output, 1 bit: result handshake from the engine.
REQ-013 SHALL have port wr_en, output, 1 bit; port wr_addr, output, 2*DIM_W bits; and port wr_data, output, DATA_W bits: output-buffer write.
REQ-014 SHALL have ports busy, done and err, output, 1 bit each: status; done and err are one-cycle pulses.

Function
REQ-015 SHALL capture in_h, in_w, kernel_size, stride and padding on an accepted start; later changes to these inputs SHALL NOT affect the running job.
REQ-016 SHALL accept start only in IDLE; start while busy SHALL be ignored.
REQ-017 SHALL implement the states IDLE, CHECK, ISSUE, WAIT, WRITE and FIN.
REQ-018 CHECK: if K=0, S=0, K>in_h+2P or K>in_w+2P, SHALL pulse err and done together one cycle later, issue no windows, and return to IDLE.
REQ-019 Otherwise SHALL initialize row=col=-P and enter ISSUE; the first win_valid SHALL appear 2 cycles after start.
REQ-020 ISSUE: win_valid=1 with win_row=row and win_col=col held stable until win_ready; on the handshake SHALL go to WAIT.
REQ-021 WAIT: res_ready=1 only in this state; on res_valid SHALL register res_data and go to WRITE.
REQ-022 WRITE: wr_en=1 for exactly one cycle, with wr_data equal to the captured result and wr_addr equal to the output index, which starts at 0 and increments by 1 per write.
REQ-023 Position advance in WRITE: if col+S+K <= in_w+P then col += S; else col=-P and row += S; then if row+K > in_h+P the job is complete and SHALL go to FIN, else SHALL go to ISSUE.
REQ-024 Boundary comparisons SHALL be done signed and at least DIM_W+2 bits wide, so that no overflow occurs at in_h=in_w=2^DIM_W-1.
REQ-025 Exactly one window SHALL be outstanding at a time, with no overlap between ISSUE and WAIT.
REQ-026 FIN: SHALL pulse done for one cycle and return to IDLE; err SHALL be 0 in this case.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 abort in any non-IDLE state SHALL go to IDLE next cycle, with no wr_en, no done and no err; a result arriving afterwards SHALL be ignored, with res_ready=0.
REQ-029 If abort and start occur in the same cycle in IDLE, start SHALL win and abort SHALL be ignored.
REQ-030 win_valid and wr_en SHALL never be asserted in the same cycle.

Reset
REQ-031 rst_n low SHALL force IDLE immediately, with all outputs 0: win_valid, win_row, win_col, res_ready, wr_en, wr_addr, wr_data, busy, done and err.
REQ-032 Reset mid-job SHALL discard all job state; the first job after reset SHALL start at wr_addr 0.

Verification
REQ-033 Scenario: in 4x4, K=3, S=1, P=0, with win_ready and res_valid tied to 1 -> origins (0,0),(0,1),(1,0),(1,1), wr_addr 0..3, then done pulse, err=0.
REQ-034 Scenario: in 5x5, K=3, S=2, P=1 -> 9 windows, rows and cols in {-1,1,3} in raster order, last wr_addr=8.
REQ-035 Scenario: S=0, or K=7 with in 2x2, P=0 -> err and done pulse at cycle start+2, with win_valid never asserted.
REQ-036 Scenario: win_ready held low 5 cycles, then res_valid delayed 3 cycles -> win_row and win_col stable while stalled, single wr_en, data matches.
REQ-037 Scenario: abort during WAIT of the 2nd window -> IDLE next cycle, busy=0, no done, late res_valid not accepted.
REQ-038 Scenario: rst_n asserted mid-job, then new start in 3x3, K=3, S=1, P=0 -> single window at (0,0), wr_addr 0, done.
